// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_feeder
//  Purpose  : Byte FIFO plus load sequencer in front of a UART transmitter.
//             Host bytes are buffered and handed to the transmitter one at a
//             time. Each load is paced on the transmitter's tx_busy handshake.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_feeder #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic          flush,
    input  logic          tx_busy,
    output logic [7:0]    tx_din,
    output logic          tx_wr_en,
    output logic [AW:0]   level,
    output logic          empty,
    output logic          full,
    output logic          overflow
);

    localparam logic [AW:0] c_LEVEL_MAX = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD      = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_empty;
    logic          r_full;
    logic          r_overflow;
    state_t        r_state;
    logic [7:0]    r_tx_din;
    logic          r_tx_wr_en;

    logic          w_push;
    logic          w_pop;
    logic [AW:0]   w_level_next;

    // Flush wins over a same-cycle push; full is the registered flag, so a
    // push while full is refused even if a pop happens in the same cycle.
    assign w_push = wr_valid && !r_full && !flush;
    // A pop only happens on the IDLE->LOAD transition of the sequencer.
    assign w_pop  = (r_state == S_IDLE) && !r_empty && !tx_busy;

    // Next occupancy; full/empty are registered from this value.
    always_comb begin
        w_level_next = r_level;
        if (flush) begin
            w_level_next = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_level_next = r_level + (AW+1)'(1);
                2'b01:   w_level_next = r_level - (AW+1)'(1);
                default: w_level_next = r_level;
            endcase
        end
    end

    // Storage write; contents need no reset since level tracks validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy, status flags and the sticky overflow bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_level <= w_level_next;
            r_empty <= (w_level_next == '0);
            r_full  <= (w_level_next == c_LEVEL_MAX);
            if (flush) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                if (wr_valid && r_full) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    // Load sequencer: hold wr_en until the transmitter raises busy, then wait
    // for busy to drop before the next pop. Flush does not disturb a byte
    // already handed over.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tx_din   <= 8'h00;
            r_tx_wr_en <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_tx_din   <= r_mem[r_rd_ptr];
                        r_tx_wr_en <= 1'b1;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (tx_busy) begin
                        r_tx_wr_en <= 1'b0;
                        r_state    <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_tx_wr_en <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign wr_ready = !r_full;
    assign tx_din   = r_tx_din;
    assign tx_wr_en = r_tx_wr_en;
    assign level    = r_level;
    assign empty    = r_empty;
    assign full     = r_full;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_feeder
//  Purpose  : Directed self-checking bench for uart_tx_feeder with a simple
//             transmitter model (fixed-length busy after each accepted load).
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_feeder;

    localparam int DEPTH    = 16;
    localparam int BUSY_LEN = 20;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [7:0] wr_data  = 8'h00;
    logic       wr_valid = 1'b0;
    logic       flush    = 1'b0;
    logic       hold_busy = 1'b0;
    logic       wr_ready;
    logic       tx_busy;
    logic [7:0] tx_din;
    logic       tx_wr_en;
    logic [4:0] level;
    logic       empty;
    logic       full;
    logic       overflow;

    int         m_cnt     = 0;
    int         cyc       = 0;
    int         n_loads   = 0;
    int         gap_bad   = 0;
    int         fall_cyc  = 0;
    bit         fall_seen = 1'b0;
    bit         prev_busy = 1'b0;
    logic [7:0] rx_q[$];

    int         total = 0;
    int         bad   = 0;

    uart_tx_feeder #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .flush    (flush),
        .tx_busy  (tx_busy),
        .tx_din   (tx_din),
        .tx_wr_en (tx_wr_en),
        .level    (level),
        .empty    (empty),
        .full     (full),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    assign tx_busy = (m_cnt != 0) || hold_busy;

    // Transmitter model: accepts a load when idle, then busy for BUSY_LEN
    // cycles; records each byte and checks the busy-fall to load spacing.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        prev_busy <= tx_busy;
        if (prev_busy && !tx_busy) begin
            fall_cyc  <= cyc;
            fall_seen <= 1'b1;
        end
        if (!rst_n) begin
            m_cnt <= 0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end else if (tx_wr_en && !hold_busy) begin
            m_cnt   <= BUSY_LEN;
            n_loads <= n_loads + 1;
            rx_q.push_back(tx_din);
            if (fall_seen && (cyc - fall_cyc) < 2) gap_bad <= gap_bad + 1;
        end
    end

    task automatic wait_drain(input int budget, input string nm);
        bit ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (empty && !tx_busy && !tx_wr_en) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_drain got=not_idle exp=idle", nm);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 8'h55;
        repeat (3) @(negedge clk);
        total++; if (level !== 5'd0)    begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
        total++; if (empty !== 1'b1)    begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
        total++; if (full !== 1'b0)     begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
        total++; if (tx_wr_en !== 1'b0) begin bad++; $display("FAIL reset_tx_wr_en got=%b exp=0", tx_wr_en); end
        total++; if (tx_din !== 8'h00)  begin bad++; $display("FAIL reset_tx_din got=%h exp=00", tx_din); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        rst_n    = 1'b1;
        wr_valid = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (level !== 5'd0) begin bad++; $display("FAIL reset_nostore_level got=%0d exp=0", level); end
        total++; if (n_loads !== 0)  begin bad++; $display("FAIL reset_nostore_loads got=%0d exp=0", n_loads); end
    endtask

    task automatic test_single();
        int base = n_loads;
        wr_valid = 1'b1;
        wr_data  = 8'h63;
        @(negedge clk);
        wr_valid = 1'b0;
        total++; if (level !== 5'd1) begin bad++; $display("FAIL single_level_n1 got=%0d exp=1", level); end
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL single_empty_n1 got=%b exp=0", empty); end
        @(negedge clk);
        total++; if (tx_wr_en !== 1'b1) begin bad++; $display("FAIL single_wr_en_n2 got=%b exp=1", tx_wr_en); end
        total++; if (tx_din !== 8'h63)  begin bad++; $display("FAIL single_din_n2 got=%h exp=63", tx_din); end
        total++; if (level !== 5'd0)    begin bad++; $display("FAIL single_level_n2 got=%0d exp=0", level); end
        @(negedge clk);
        total++; if (tx_wr_en !== 1'b1) begin bad++; $display("FAIL single_wr_en_hold got=%b exp=1", tx_wr_en); end
        @(negedge clk);
        total++; if (tx_wr_en !== 1'b0) begin bad++; $display("FAIL single_wr_en_drop got=%b exp=0", tx_wr_en); end
        wait_drain(100, "single");
        total++; if (n_loads !== base + 1) begin bad++; $display("FAIL single_loads got=%0d exp=%0d", n_loads, base + 1); end
        total++; if (rx_q[rx_q.size()-1] !== 8'h63) begin bad++; $display("FAIL single_rx got=%h exp=63", rx_q[rx_q.size()-1]); end
    endtask

    task automatic test_burst();
        int base  = n_loads;
        int rbase = rx_q.size();
        int g0    = gap_bad;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'hA0 + i);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        wait_drain(400, "burst");
        total++; if (n_loads !== base + 5) begin bad++; $display("FAIL burst_loads got=%0d exp=%0d", n_loads, base + 5); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rx_q[rbase+i] !== 8'(8'hA0 + i)) begin
                bad++; $display("FAIL burst_byte%0d got=%h exp=%h", i, rx_q[rbase+i], 8'(8'hA0 + i));
            end
        end
        total++; if (gap_bad !== g0) begin bad++; $display("FAIL burst_gap got=%0d exp=%0d", gap_bad - g0, 0); end
    endtask

    task automatic test_full_overflow();
        int base  = n_loads;
        int rbase = rx_q.size();
        hold_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            if (i == 16) begin
                total++; if (full !== 1'b1)      begin bad++; $display("FAIL full_flag got=%b exp=1", full); end
                total++; if (wr_ready !== 1'b0)  begin bad++; $display("FAIL full_wr_ready got=%b exp=0", wr_ready); end
                total++; if (level !== 5'd16)    begin bad++; $display("FAIL full_level got=%0d exp=16", level); end
            end
            wr_valid = 1'b1;
            wr_data  = 8'(8'h10 + i);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL full_overflow got=%b exp=1", overflow); end
        total++; if (level !== 5'd16)   begin bad++; $display("FAIL full_level_after17 got=%0d exp=16", level); end
        hold_busy = 1'b0;
        wait_drain(1000, "full");
        total++; if (n_loads !== base + 16) begin bad++; $display("FAIL full_drain_loads got=%0d exp=%0d", n_loads, base + 16); end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (rx_q[rbase+i] !== 8'(8'h10 + i)) begin
                bad++; $display("FAIL full_byte%0d got=%h exp=%h", i, rx_q[rbase+i], 8'(8'h10 + i));
            end
        end
    endtask

    task automatic test_wrap_stream();
        int  base    = n_loads;
        int  rbase   = rx_q.size();
        int  pushed  = 0;
        int  exp_lvl = 0;
        int  lvl_bad = 0;
        int  over    = 0;
        int  both    = 0;
        bit  done    = 1'b0;
        bit  push_now;
        bit  pop_now;
        logic prev_en = tx_wr_en;
        for (int k = 0; k < 3000; k++) begin
            push_now = (pushed < 40) && (wr_ready === 1'b1);
            wr_valid = push_now;
            wr_data  = 8'(8'h40 + pushed);
            @(negedge clk);
            if (push_now) pushed++;
            pop_now = (tx_wr_en === 1'b1) && (prev_en !== 1'b1);
            prev_en = tx_wr_en;
            exp_lvl = exp_lvl + int'(push_now) - int'(pop_now);
            if (push_now && pop_now) both++;
            if (int'(level) != exp_lvl) lvl_bad++;
            if (int'(level) > DEPTH) over++;
            if (pushed == 40 && empty && !tx_busy && !tx_wr_en) begin
                done = 1'b1;
                break;
            end
        end
        wr_valid = 1'b0;
        total++; if (!done)                  begin bad++; $display("FAIL wrap_done got=0 exp=1"); end
        total++; if (n_loads !== base + 40)  begin bad++; $display("FAIL wrap_loads got=%0d exp=%0d", n_loads, base + 40); end
        total++; if (lvl_bad !== 0)          begin bad++; $display("FAIL wrap_level_track got=%0d exp=0", lvl_bad); end
        total++; if (over !== 0)             begin bad++; $display("FAIL wrap_level_max got=%0d exp=0", over); end
        total++; if (both < 1)               begin bad++; $display("FAIL wrap_push_pop_seen got=%0d exp=>0", both); end
        for (int i = 0; i < 40; i++) begin
            total++;
            if (rx_q.size() <= rbase + i || rx_q[rbase+i] !== 8'(8'h40 + i)) begin
                bad++; $display("FAIL wrap_byte%0d got=%h exp=%h", i, (rx_q.size() > rbase + i) ? rx_q[rbase+i] : 8'hxx, 8'(8'h40 + i));
            end
        end
    endtask

    task automatic test_flush();
        int base  = n_loads;
        int rbase = rx_q.size();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL flush_pre_overflow got=%b exp=1", overflow); end
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h70 + i);
            @(negedge clk);
        end
        total++; if (level !== 5'd5)    begin bad++; $display("FAIL flush_pre_level got=%0d exp=5", level); end
        total++; if (tx_busy !== 1'b1)  begin bad++; $display("FAIL flush_pre_busy got=%b exp=1", tx_busy); end
        total++; if (tx_wr_en !== 1'b0) begin bad++; $display("FAIL flush_pre_wr_en got=%b exp=0", tx_wr_en); end
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        @(negedge clk);
        flush    = 1'b0;
        wr_valid = 1'b0;
        total++; if (level !== 5'd0)    begin bad++; $display("FAIL flush_level got=%0d exp=0", level); end
        total++; if (empty !== 1'b1)    begin bad++; $display("FAIL flush_empty got=%b exp=1", empty); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL flush_overflow got=%b exp=0", overflow); end
        wait_drain(200, "flush");
        total++; if (n_loads !== base + 1)  begin bad++; $display("FAIL flush_loads got=%0d exp=%0d", n_loads, base + 1); end
        total++; if (rx_q[rbase] !== 8'h70) begin bad++; $display("FAIL flush_inflight got=%h exp=70", rx_q[rbase]); end
        wr_valid = 1'b1;
        wr_data  = 8'h99;
        @(negedge clk);
        wr_valid = 1'b0;
        wait_drain(200, "flush_next");
        total++; if (n_loads !== base + 2) begin bad++; $display("FAIL flush_next_loads got=%0d exp=%0d", n_loads, base + 2); end
        total++; if (rx_q[rx_q.size()-1] !== 8'h99) begin bad++; $display("FAIL flush_next_byte got=%h exp=99", rx_q[rx_q.size()-1]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full_overflow();
        test_wrap_stream();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
